// File: rtl/ws2811_bit_encoder.sv
// ws2811_bit_encoder: pops GRB command words from the pixel FIFO and drives the
// WS2811 single-wire line with fixed-period bit cells, repeats and optional latch.
//
// state   | meaning
// IDLE    | line low, waiting for a non-empty FIFO
// REQ     | one-cycle FIFO read request
// WAIT    | read data expected; missing data returns to IDLE
// HIGH    | high part of the current bit cell
// LOW     | low remainder of the bit cell, then next bit / repeat / latch / idle
// LATCH   | reset-low period that latches the LED chain
module ws2811_bit_encoder #(
   parameter int unsigned T0H_CYCLES   = 25,
   parameter int unsigned T1H_CYCLES   = 60,
   parameter int unsigned BIT_CYCLES   = 125,
   parameter int unsigned RESET_CYCLES = 2800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [57:0] fifo_dout,
   input  logic        fifo_empty,
   input  logic        fifo_valid,
   output logic        fifo_rd_en,
   output logic        led_out,
   output logic        busy
);

   localparam int unsigned MAX_CYCLES = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);

   // Counters hold "cycles remaining minus one", so terminal count is zero.
   localparam logic [CNT_W-1:0] T0H_LOAD = CNT_W'(T0H_CYCLES - 1);
   localparam logic [CNT_W-1:0] T1H_LOAD = CNT_W'(T1H_CYCLES - 1);
   localparam logic [CNT_W-1:0] T0L_LOAD = CNT_W'(BIT_CYCLES - T0H_CYCLES - 1);
   localparam logic [CNT_W-1:0] T1L_LOAD = CNT_W'(BIT_CYCLES - T1H_CYCLES - 1);
   localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HIGH,
      S_LOW,
      S_LATCH
   } state_t;

   state_t           state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [4:0]       bit_idx_q, bit_idx_d;
   logic [9:0]       rep_q,     rep_d;
   logic [23:0]      colour_q,  colour_d;
   logic             latch_q,   latch_d;
   logic             led_q,     led_d;
   logic             rd_en_q,   rd_en_d;
   logic             busy_q,    busy_d;

   logic [9:0]       word_rep;
   logic [4:0]       nxt_idx;
   logic             unused_reserved;

   assign word_rep        = fifo_dout[33:24];
   assign unused_reserved = ^fifo_dout[57:35];

   function automatic logic [CNT_W-1:0] high_load(input logic b);
      return b ? T1H_LOAD : T0H_LOAD;
   endfunction

   function automatic logic [CNT_W-1:0] low_load(input logic b);
      return b ? T1L_LOAD : T0L_LOAD;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      rep_d     = rep_q;
      colour_d  = colour_q;
      latch_d   = latch_q;
      nxt_idx   = bit_idx_q - 5'd1;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               state_d = S_REQ;
            end
         end

         S_REQ: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (fifo_valid) begin
               colour_d  = fifo_dout[23:0];
               rep_d     = (word_rep == 10'd0) ? 10'd1 : word_rep;
               latch_d   = fifo_dout[34];
               bit_idx_d = 5'd23;
               cnt_d     = high_load(fifo_dout[23]);
               state_d   = S_HIGH;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_HIGH: begin
            if (cnt_q == '0) begin
               cnt_d   = low_load(colour_q[bit_idx_q]);
               state_d = S_LOW;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_LOW: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (bit_idx_q != 5'd0) begin
               bit_idx_d = nxt_idx;
               cnt_d     = high_load(colour_q[nxt_idx]);
               state_d   = S_HIGH;
            end else if (rep_q > 10'd1) begin
               rep_d     = rep_q - 10'd1;
               bit_idx_d = 5'd23;
               cnt_d     = high_load(colour_q[23]);
               state_d   = S_HIGH;
            end else if (latch_q) begin
               cnt_d   = RST_LOAD;
               state_d = S_LATCH;
            end else begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end

         S_LATCH: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they align with state_q.
      led_d   = (state_d == S_HIGH);
      rd_en_d = (state_d == S_REQ);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         rep_q     <= '0;
         colour_q  <= '0;
         latch_q   <= 1'b0;
         led_q     <= 1'b0;
         rd_en_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         rep_q     <= rep_d;
         colour_q  <= colour_d;
         latch_q   <= latch_d;
         led_q     <= led_d;
         rd_en_q   <= rd_en_d;
         busy_q    <= busy_d;
      end
   end

   assign fifo_rd_en = rd_en_q;
   assign led_out    = led_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ws2811_bit_encoder.sv
// Bench for ws2811_bit_encoder: a queue-driven FIFO model plus a per-cycle
// waveform model of the line, busy and read request derived from the word format.
module tb_ws2811_bit_encoder;

   localparam int T0H  = 25;
   localparam int T1H  = 60;
   localparam int BITC = 125;
   localparam int RSTC = 2800;

   logic        clk = 1'b0;
   logic        rst;
   logic [57:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_valid;
   logic        fifo_rd_en;
   logic        led_out;
   logic        busy;

   always #5 clk = ~clk;

   ws2811_bit_encoder #(
      .T0H_CYCLES  (T0H),
      .T1H_CYCLES  (T1H),
      .BIT_CYCLES  (BITC),
      .RESET_CYCLES(RSTC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_dout (fifo_dout),
      .fifo_empty(fifo_empty),
      .fifo_valid(fifo_valid),
      .fifo_rd_en(fifo_rd_en),
      .led_out   (led_out),
      .busy      (busy)
   );

   typedef struct packed {
      logic led;
      logic bsy;
      logic rd;
      logic is_wait;
   } cyc_t;

   cyc_t        sched[$];
   logic [57:0] fifo_q[$];
   bit          drop_valid = 1'b0;
   bit          check_en   = 1'b0;
   int          total = 0;
   int          bad   = 0;

   int   hi_runs[$];
   int   lo_runs[$];
   int   run_len  = 0;
   logic led_prev = 1'b0;
   logic rd_prev  = 1'b0;
   int   rd_cnt   = 0;
   int   rd_rise  = 0;
   int   pv_cnt   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Expected line/busy/rd_en for every cycle of one word, starting the cycle after valid.
   function automatic void push_word(input logic [57:0] w);
      cyc_t hi;
      cyc_t lo;
      int   reps;
      int   th;
      hi   = '{led: 1'b1, bsy: 1'b1, rd: 1'b0, is_wait: 1'b0};
      lo   = '{led: 1'b0, bsy: 1'b1, rd: 1'b0, is_wait: 1'b0};
      reps = (w[33:24] == 10'd0) ? 1 : int'(w[33:24]);
      for (int r = 0; r < reps; r++) begin
         for (int b = 23; b >= 0; b--) begin
            th = w[b] ? T1H : T0H;
            for (int k = 0; k < th; k++) sched.push_back(hi);
            for (int k = 0; k < BITC - th; k++) sched.push_back(lo);
         end
      end
      if (w[34]) begin
         for (int k = 0; k < RSTC; k++) sched.push_back(lo);
      end
   endfunction

   // Compare process: one model step per cycle, sampled mid-cycle.
   initial begin
      cyc_t e;
      cyc_t req_c;
      cyc_t wait_c;
      bit   idle_now;
      req_c  = '{led: 1'b0, bsy: 1'b1, rd: 1'b1, is_wait: 1'b0};
      wait_c = '{led: 1'b0, bsy: 1'b1, rd: 1'b0, is_wait: 1'b1};
      forever begin
         @(negedge clk);
         if (check_en) begin
            if (sched.size() > 0) begin
               e        = sched.pop_front();
               idle_now = 1'b0;
            end else begin
               e        = '0;
               idle_now = 1'b1;
            end
            chk("led_out", 32'(led_out), 32'(e.led));
            chk("busy", 32'(busy), 32'(e.bsy));
            chk("fifo_rd_en", 32'(fifo_rd_en), 32'(e.rd));
            if (rst === 1'b1) begin
               sched.delete();
            end else if (idle_now && fifo_empty === 1'b0) begin
               sched.push_back(req_c);
               sched.push_back(wait_c);
            end else if (e.is_wait && fifo_valid === 1'b1) begin
               push_word(fifo_dout);
            end
         end
      end
   end

   // Statistics monitor: run lengths of the line, read pulses, busy time after valid.
   initial begin
      forever begin
         @(negedge clk);
         if (check_en) begin
            if (led_out === led_prev) begin
               run_len++;
            end else begin
               if (led_prev === 1'b1) hi_runs.push_back(run_len);
               else                   lo_runs.push_back(run_len);
               run_len = 1;
            end
            led_prev = led_out;
            if (fifo_rd_en === 1'b1) begin
               rd_cnt++;
               if (rd_prev !== 1'b1) rd_rise++;
            end
            rd_prev = fifo_rd_en;
            if (fifo_valid === 1'b1)  pv_cnt = 0;
            else if (busy === 1'b1)   pv_cnt++;
         end
      end
   end

   // FIFO model: data and valid appear one cycle after an accepted read.
   initial begin
      logic rd_now;
      fifo_valid = 1'b0;
      fifo_empty = 1'b1;
      fifo_dout  = '0;
      forever begin
         @(negedge clk);
         rd_now = fifo_rd_en;
         @(posedge clk);
         #1;
         if (rd_now === 1'b1 && !drop_valid && fifo_q.size() > 0) begin
            fifo_dout  = fifo_q.pop_front();
            fifo_valid = 1'b1;
         end else begin
            fifo_valid = 1'b0;
            fifo_dout  = {26'($urandom), $urandom};
            if (rd_now === 1'b1) drop_valid = 1'b0;
         end
         fifo_empty = (fifo_q.size() == 0);
      end
   end

   task automatic push(input logic [23:0] col, input int rep, input bit lat);
      logic [57:0] w;
      w = {23'($urandom), lat, 10'(rep), col};
      fifo_q.push_back(w);
   endtask

   task automatic clear_stats();
      hi_runs.delete();
      lo_runs.delete();
      run_len = 0;
      rd_cnt  = 0;
      rd_rise = 0;
      pv_cnt  = 0;
   endtask

   task automatic run_until_idle(input string nm, input int max_cyc);
      int n;
      n = 0;
      repeat (4) @(negedge clk);
      while ((busy !== 1'b0 || fifo_q.size() != 0) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(n < max_cyc), 32'd1);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      @(posedge clk);
      #1 check_en = 1'b1;
      @(negedge clk);
      chk("reset_led", 32'(led_out), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single word, R=1, no latch.
      clear_stats();
      push(24'hAA55F0, 1, 1'b0);
      run_until_idle("t1_done", 20000);
      chk("t1_bits", 32'(hi_runs.size()), 32'd24);
      chk("t1_hi0", 32'(hi_runs[0]), 32'd60);
      chk("t1_hi1", 32'(hi_runs[1]), 32'd25);
      chk("t1_hi8", 32'(hi_runs[8]), 32'd25);
      chk("t1_hi9", 32'(hi_runs[9]), 32'd60);
      chk("t1_hi16", 32'(hi_runs[16]), 32'd60);
      chk("t1_hi23", 32'(hi_runs[23]), 32'd25);
      chk("t1_lo_after_1", 32'(lo_runs[1]), 32'd65);
      chk("t1_lo_after_0", 32'(lo_runs[2]), 32'd100);
      chk("t1_rd_pulses", 32'(rd_cnt), 32'd1);
      chk("t1_busy_after_valid", 32'(pv_cnt), 32'd3000);

      // R=3 with latch.
      clear_stats();
      push(24'h000001, 3, 1'b1);
      run_until_idle("t2_done", 30000);
      chk("t2_bits", 32'(hi_runs.size()), 32'd72);
      chk("t2_hi0", 32'(hi_runs[0]), 32'd25);
      chk("t2_hi22", 32'(hi_runs[22]), 32'd25);
      chk("t2_hi23", 32'(hi_runs[23]), 32'd60);
      chk("t2_hi47", 32'(hi_runs[47]), 32'd60);
      chk("t2_hi71", 32'(hi_runs[71]), 32'd60);
      chk("t2_busy_after_valid", 32'(pv_cnt), 32'd11800);
      chk("t2_rd_pulses", 32'(rd_cnt), 32'd1);

      // R=0 behaves as R=1.
      clear_stats();
      push(24'hC3A501, 0, 1'b0);
      run_until_idle("t3_done", 20000);
      chk("t3_bits", 32'(hi_runs.size()), 32'd24);
      chk("t3_hi0", 32'(hi_runs[0]), 32'd60);
      chk("t3_hi23", 32'(hi_runs[23]), 32'd60);
      chk("t3_busy_after_valid", 32'(pv_cnt), 32'd3000);

      // Two words back to back.
      clear_stats();
      push(24'h0F0F0E, 1, 1'b0);
      push(24'hF00001, 1, 1'b0);
      run_until_idle("t4_done", 20000);
      chk("t4_bits", 32'(hi_runs.size()), 32'd48);
      chk("t4_rd_cycles", 32'(rd_cnt), 32'd2);
      chk("t4_rd_pulses", 32'(rd_rise), 32'd2);
      chk("t4_gap_low", 32'(lo_runs[24]), 32'd103);
      chk("t4_hi24", 32'(hi_runs[24]), 32'd60);

      // Forced underflow in WAIT, then normal delivery.
      clear_stats();
      drop_valid = 1'b1;
      push(24'h5A5A5A, 1, 1'b0);
      run_until_idle("t5_done", 20000);
      chk("t5_rd_pulses", 32'(rd_cnt), 32'd2);
      chk("t5_bits", 32'(hi_runs.size()), 32'd24);
      chk("t5_hi0", 32'(hi_runs[0]), 32'd25);

      // Reset on the 30th cycle of a '1' high phase.
      clear_stats();
      push(24'hFFFFFF, 1, 1'b0);
      n = 0;
      while (led_out !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t6_started", 32'(n < 50), 32'd1);
      repeat (29) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_led_after_rst", 32'(led_out), 32'd0);
      chk("t6_busy_after_rst", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      chk("t6_hi_len", 32'(hi_runs[0]), 32'd30);
      chk("t6_no_reread", 32'(rd_cnt), 32'd1);
      clear_stats();
      push(24'h123456, 2, 1'b0);
      run_until_idle("t6_done", 20000);
      chk("t6_bits", 32'(hi_runs.size()), 32'd48);
      chk("t6_rd_pulses", 32'(rd_cnt), 32'd1);

      // Randomized words, gaps, underflows and one mid-stream reset.
      for (int i = 0; i < 5; i++) begin
         if ($urandom_range(0, 3) == 0) drop_valid = 1'b1;
         push(24'($urandom), int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(5, 2500)) @(negedge clk);
         if (i == 2) begin
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
      end
      run_until_idle("rand_done", 60000);
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
